scanline_scheduler: RTL and testbench

//  Per-scanline sequencer for the sprite pipeline. On each line boundary it starts prepare_line,

---
 rtl/scanline_scheduler_if.sv | 36 +++
 rtl/scanline_scheduler.sv | 137 +++++++++++++
 tb/tb_scanline_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/scanline_scheduler_if.sv
// Signal bundle between the scanline scheduler and the display timing, prepare_line,
// sprite_drawer and OAM datapath. The scheduler side uses the master modport.
interface scanline_scheduler_if #(
    parameter int CORDW     = 10,
    parameter int OAM_AW    = 6,
    parameter int OVR_CNT_W = 8
);
    logic [CORDW-1:0]     sy;
    logic                 prep_start;
    logic                 prep_done;
    logic                 draw_start;
    logic                 draw_done;
    logic                 abort;
    logic [CORDW-1:0]     target_line;
    logic [OAM_AW-1:0]    oam_addr_prep;
    logic [OAM_AW-1:0]    oam_addr_draw;
    logic [OAM_AW-1:0]    oam_addr;
    logic                 buf_sel;
    logic                 busy;
    logic                 ovr_clr;
    logic                 overrun;
    logic [OVR_CNT_W-1:0] ovr_count;
    logic [1:0]           state_dbg;

    modport master (
        input  sy, prep_done, draw_done, oam_addr_prep, oam_addr_draw, ovr_clr,
        output prep_start, draw_start, abort, target_line, oam_addr, buf_sel,
               busy, overrun, ovr_count, state_dbg
    );

    modport slave (
        output sy, prep_done, draw_done, oam_addr_prep, oam_addr_draw, ovr_clr,
        input  prep_start, draw_start, abort, target_line, oam_addr, buf_sel,
               busy, overrun, ovr_count, state_dbg
    );
endinterface

// File: rtl/scanline_scheduler.sv
// Per-scanline sequencer: starts prepare_line then sprite_drawer for line sy+1, muxes the
// OAM read port, flips the ping-pong line buffer, and counts/aborts lines that overrun.
module scanline_scheduler #(
    parameter int CORDW     = 10,
    parameter int V_RES     = 480,
    parameter int V_TOTAL   = 525,
    parameter int OAM_AW    = 6,
    parameter int OVR_CNT_W = 8
) (
    input logic clk_pix,
    input logic btn_rst,
    scanline_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;

    localparam logic [CORDW-1:0] LAST_LINE = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] VIS_LINES = CORDW'(V_RES);

    // Handshake: prep_start/draw_start/abort are single-cycle pulses; prep_done is only
    // looked at in PREP and draw_done only in DRAW, so either may be a level or a pulse.
    state_t               state_q, state_d;
    logic [CORDW-1:0]     sy_prev_q, sy_prev_d;
    logic [CORDW-1:0]     target_line_q, target_line_d;
    logic                 prep_start_q, prep_start_d;
    logic                 draw_start_q, draw_start_d;
    logic                 abort_q, abort_d;
    logic                 buf_sel_q, buf_sel_d;
    logic                 overrun_q, overrun_d;
    logic [OVR_CNT_W-1:0] ovr_count_q, ovr_count_d;

    logic                 line_tick;
    logic                 ovr_event;
    logic [CORDW-1:0]     t_line;
    logic [OAM_AW-1:0]    oam_addr_mux;

    always_ff @(posedge clk_pix or negedge btn_rst) begin
        if (!btn_rst) begin
            state_q       <= IDLE;
            sy_prev_q     <= '1;
            target_line_q <= '0;
            prep_start_q  <= 1'b0;
            draw_start_q  <= 1'b0;
            abort_q       <= 1'b0;
            buf_sel_q     <= 1'b0;
            overrun_q     <= 1'b0;
            ovr_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            sy_prev_q     <= sy_prev_d;
            target_line_q <= target_line_d;
            prep_start_q  <= prep_start_d;
            draw_start_q  <= draw_start_d;
            abort_q       <= abort_d;
            buf_sel_q     <= buf_sel_d;
            overrun_q     <= overrun_d;
            ovr_count_q   <= ovr_count_d;
        end
    end

    always_comb begin
        line_tick     = (bus.sy != sy_prev_q);
        t_line        = (bus.sy == LAST_LINE) ? '0 : bus.sy + CORDW'(1);
        sy_prev_d     = bus.sy;
        state_d       = state_q;
        target_line_d = target_line_q;
        prep_start_d  = 1'b0;
        draw_start_d  = 1'b0;
        abort_d       = 1'b0;
        buf_sel_d     = buf_sel_q;
        ovr_event     = 1'b0;

        if (line_tick) begin
            target_line_d = t_line;
            // A draw finishing on the boundary cycle still counts as a completed line.
            if (state_q == PREP || (state_q == DRAW && !bus.draw_done)) begin
                ovr_event = 1'b1;
                abort_d   = 1'b1;
            end else if (state_q == DONE || state_q == DRAW) begin
                buf_sel_d = ~buf_sel_q;
            end
            if (t_line < VIS_LINES) begin
                state_d      = PREP;
                prep_start_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                PREP: begin
                    if (bus.prep_done) begin
                        state_d      = DRAW;
                        draw_start_d = 1'b1;
                    end
                end
                DRAW: begin
                    if (bus.draw_done) state_d = DONE;
                end
                default: state_d = state_q;
            endcase
        end

        overrun_d   = overrun_q;
        ovr_count_d = ovr_count_q;
        // An overrun in the same cycle as a clear wins, leaving a count of one.
        if (ovr_event) begin
            overrun_d = 1'b1;
            if (bus.ovr_clr) begin
                ovr_count_d = OVR_CNT_W'(1);
            end else if (ovr_count_q != '1) begin
                ovr_count_d = ovr_count_q + OVR_CNT_W'(1);
            end
        end else if (bus.ovr_clr) begin
            overrun_d   = 1'b0;
            ovr_count_d = '0;
        end
    end

    always_comb begin
        oam_addr_mux = '0;
        case (state_q)
            PREP:    oam_addr_mux = bus.oam_addr_prep;
            DRAW:    oam_addr_mux = bus.oam_addr_draw;
            default: oam_addr_mux = '0;
        endcase
    end

    assign bus.prep_start  = prep_start_q;
    assign bus.draw_start  = draw_start_q;
    assign bus.abort       = abort_q;
    assign bus.target_line = target_line_q;
    assign bus.oam_addr    = oam_addr_mux;
    assign bus.buf_sel     = buf_sel_q;
    assign bus.busy        = (state_q == PREP) || (state_q == DRAW);
    assign bus.overrun     = overrun_q;
    assign bus.ovr_count   = ovr_count_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_scanline_scheduler.sv
// Directed bench for scanline_scheduler: line sequencing, overrun/abort, blanking, OAM mux,
// counter saturation and clear, and asynchronous reset.
module tb_scanline_scheduler;
    localparam int CORDW     = 10;
    localparam int OAM_AW    = 6;
    localparam int OVR_CNT_W = 8;

    localparam int S_IDLE = 0;
    localparam int S_PREP = 1;
    localparam int S_DRAW = 2;
    localparam int S_DONE = 3;

    logic clk_pix = 1'b0;
    logic btn_rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    scanline_scheduler_if #(.CORDW(CORDW), .OAM_AW(OAM_AW), .OVR_CNT_W(OVR_CNT_W)) bus ();

    scanline_scheduler #(
        .CORDW(CORDW), .V_RES(480), .V_TOTAL(525), .OAM_AW(OAM_AW), .OVR_CNT_W(OVR_CNT_W)
    ) dut (
        .clk_pix(clk_pix),
        .btn_rst(btn_rst),
        .bus(bus)
    );

    // clock / reset
    always #5 clk_pix = ~clk_pix;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},    32'(bus.state_dbg),   S_IDLE);
        chk({tag, "_pstart"},   32'(bus.prep_start),  0);
        chk({tag, "_dstart"},   32'(bus.draw_start),  0);
        chk({tag, "_abort"},    32'(bus.abort),       0);
        chk({tag, "_bufsel"},   32'(bus.buf_sel),     0);
        chk({tag, "_target"},   32'(bus.target_line), 0);
        chk({tag, "_overrun"},  32'(bus.overrun),     0);
        chk({tag, "_ovrcnt"},   32'(bus.ovr_count),   0);
        chk({tag, "_busy"},     32'(bus.busy),        0);
        chk({tag, "_oam"},      32'(bus.oam_addr),    0);
    endtask

    // driver tasks: one-cycle done pulses
    task automatic pulse_prep_done();
        bus.prep_done = 1'b1;
        cyc(1);
        bus.prep_done = 1'b0;
    endtask

    task automatic pulse_draw_done();
        bus.draw_done = 1'b1;
        cyc(1);
        bus.draw_done = 1'b0;
    endtask

    initial begin
        bus.sy            = 10'd9;
        bus.prep_done     = 1'b0;
        bus.draw_done     = 1'b0;
        bus.oam_addr_prep = 6'd5;
        bus.oam_addr_draw = 6'd9;
        bus.ovr_clr       = 1'b0;

        #2;
        chk_reset_vals("rst");
        btn_rst = 1'b1;

        // first cycle after release ticks: target 10 scheduled
        cyc(1);
        chk("init_pstart", 32'(bus.prep_start), 1);
        chk("init_target", 32'(bus.target_line), 10);
        chk("init_state", 32'(bus.state_dbg), S_PREP);
        chk("oam_prep", 32'(bus.oam_addr), 5);
        chk("busy_prep", 32'(bus.busy), 1);
        cyc(1);
        chk("pstart_one_cycle", 32'(bus.prep_start), 0);
        pulse_prep_done();
        chk("init_dstart", 32'(bus.draw_start), 1);
        chk("oam_draw", 32'(bus.oam_addr), 9);
        pulse_draw_done();
        chk("done_state", 32'(bus.state_dbg), S_DONE);
        chk("oam_done", 32'(bus.oam_addr), 0);
        chk("busy_done", 32'(bus.busy), 0);

        // sy 9->10 from DONE: toggle, target 11, prep 20 cycles
        bus.sy = 10'd10;
        cyc(1);
        chk("t1_bufsel", 32'(bus.buf_sel), 1);
        chk("t1_target", 32'(bus.target_line), 11);
        chk("t1_pstart", 32'(bus.prep_start), 1);
        chk("t1_abort", 32'(bus.abort), 0);
        cyc(19);
        chk("t1_wait_state", 32'(bus.state_dbg), S_PREP);
        chk("t1_wait_dstart", 32'(bus.draw_start), 0);
        pulse_prep_done();
        chk("t1_dstart", 32'(bus.draw_start), 1);
        chk("t1_draw_state", 32'(bus.state_dbg), S_DRAW);
        cyc(1);
        chk("t1_dstart_one", 32'(bus.draw_start), 0);
        pulse_draw_done();
        chk("t1_done", 32'(bus.state_dbg), S_DONE);
        bus.sy = 10'd11;
        cyc(1);
        chk("t1b_bufsel", 32'(bus.buf_sel), 0);
        chk("t1b_target", 32'(bus.target_line), 12);
        pulse_prep_done();
        pulse_draw_done();

        // overrun: draw_done held low across sy 20->21
        bus.sy = 10'd20;
        cyc(1);
        chk("t2_pre_bufsel", 32'(bus.buf_sel), 1);
        pulse_prep_done();
        chk("t2_in_draw", 32'(bus.state_dbg), S_DRAW);
        bus.sy = 10'd21;
        cyc(1);
        chk("t2_abort", 32'(bus.abort), 1);
        chk("t2_pstart", 32'(bus.prep_start), 1);
        chk("t2_overrun", 32'(bus.overrun), 1);
        chk("t2_ovrcnt", 32'(bus.ovr_count), 1);
        chk("t2_bufsel", 32'(bus.buf_sel), 1);
        chk("t2_target", 32'(bus.target_line), 22);
        cyc(1);
        chk("t2_abort_one", 32'(bus.abort), 0);

        // draw_done on the tick cycle: completed line
        pulse_prep_done();
        bus.sy = 10'd22;
        bus.draw_done = 1'b1;
        cyc(1);
        bus.draw_done = 1'b0;
        chk("t3_abort", 32'(bus.abort), 0);
        chk("t3_ovrcnt", 32'(bus.ovr_count), 1);
        chk("t3_bufsel", 32'(bus.buf_sel), 0);
        chk("t3_pstart", 32'(bus.prep_start), 1);

        // prep_done on the tick cycle: overrun
        bus.sy = 10'd23;
        bus.prep_done = 1'b1;
        cyc(1);
        bus.prep_done = 1'b0;
        chk("t3b_abort", 32'(bus.abort), 1);
        chk("t3b_ovrcnt", 32'(bus.ovr_count), 2);
        chk("t3b_dstart", 32'(bus.draw_start), 0);
        chk("t3b_bufsel", 32'(bus.buf_sel), 0);
        pulse_prep_done();
        pulse_draw_done();

        // blanking boundaries
        bus.sy = 10'd478;
        cyc(1);
        chk("t4_478_target", 32'(bus.target_line), 479);
        chk("t4_478_state", 32'(bus.state_dbg), S_PREP);
        chk("t4_478_bufsel", 32'(bus.buf_sel), 1);
        pulse_prep_done();
        pulse_draw_done();
        bus.sy = 10'd479;
        cyc(1);
        chk("t4_479_target", 32'(bus.target_line), 480);
        chk("t4_479_state", 32'(bus.state_dbg), S_IDLE);
        chk("t4_479_pstart", 32'(bus.prep_start), 0);
        chk("t4_479_bufsel", 32'(bus.buf_sel), 0);
        chk("oam_idle", 32'(bus.oam_addr), 0);
        bus.sy = 10'd480;
        cyc(1);
        chk("t4_480_state", 32'(bus.state_dbg), S_IDLE);
        bus.sy = 10'd524;
        cyc(1);
        chk("t4_524_target", 32'(bus.target_line), 0);
        chk("t4_524_pstart", 32'(bus.prep_start), 1);
        chk("t4_524_bufsel", 32'(bus.buf_sel), 0);
        pulse_prep_done();
        pulse_draw_done();
        bus.sy = 10'd0;
        cyc(1);
        chk("t4_0_target", 32'(bus.target_line), 1);
        chk("t4_0_state", 32'(bus.state_dbg), S_PREP);
        chk("t4_0_bufsel", 32'(bus.buf_sel), 1);

        // 300 back-to-back overruns saturate the counter
        for (int i = 0; i < 300; i++) begin
            bus.sy = (i % 2 == 0) ? 10'd1 : 10'd0;
            cyc(1);
        end
        chk("t6_sat", 32'(bus.ovr_count), 255);
        chk("t6_overrun", 32'(bus.overrun), 1);
        chk("t6_bufsel", 32'(bus.buf_sel), 1);
        chk("t6_abort", 32'(bus.abort), 1);

        bus.ovr_clr = 1'b1;
        cyc(1);
        chk("t6_clr_overrun", 32'(bus.overrun), 0);
        chk("t6_clr_cnt", 32'(bus.ovr_count), 0);
        bus.sy = 10'd1;
        cyc(1);
        bus.ovr_clr = 1'b0;
        chk("t6_clrset_overrun", 32'(bus.overrun), 1);
        chk("t6_clrset_cnt", 32'(bus.ovr_count), 1);

        // async reset in the middle of DRAW
        pulse_prep_done();
        chk("t6_pre_rst_state", 32'(bus.state_dbg), S_DRAW);
        btn_rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        #2;
        btn_rst = 1'b1;
        cyc(1);
        chk("post_rst_abort", 32'(bus.abort), 0);
        chk("post_rst_pstart", 32'(bus.prep_start), 1);
        chk("post_rst_target", 32'(bus.target_line), 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
